mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported memory bus between the instruction-fetch port (I) and the EX-stage data port (D).
- D carries loads, stores and the byte-enable write mask; I carries fetch reads only.
- Policy: fixed priority to D, with an anti-starvation guarantee for I.
- Provides request/acknowledge handshakes to both ports, registered bus outputs, and a per-transaction bus timeout.

Parameters:
- STARVE_LIMIT, 4: consecutive D grants allowed while I is waiting before I is forced to win.
- TIMEOUT, 255: bus cycles to wait for busAck before the transaction is aborted (used only with the optional feature).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- iReq  in  1  I-port fetch request; held stable until iAck or iErr.
- iAddr  in  32  I-port word address.
- iAck  out  1  one-cycle pulse: fetch done, iData valid this cycle.
- iData  out  32  fetch read data.
- iErr  out  1  one-cycle pulse: fetch aborted by timeout.
- dReq  in  1  D-port request; held stable until dAck or dErr.
- dAddr  in  32  D-port byte address.
- dWrite  in  4  byte write enables; 0000 means a read.
- dWData  in  32  store data, already lane-rotated.
- dAck  out  1  one-cycle pulse: access done, dRData valid this cycle.
- dRData  out  32  load read data.
- dErr  out  1  one-cycle pulse: access aborted by timeout.
- busReq  out  1  bus request, registered.
- busAddr  out  32  bus address, registered.
- busWe  out  4  bus byte enables, registered.
- busWData  out  32  bus write data, registered.
- busAck  in  1  bus completion pulse.
- busRData  in  32  bus read data, valid with busAck.
- grantD  out  1  1 while the current or last owner is D (debug).

Behaviour:
- Reset (rstn low, asynchronous, any state):
  - state goes to IDLE; starveCnt=0; grantD=0.
  - busReq=0, busAddr=0, busWe=0, busWData=0.
  - iAck, dAck, iErr and dErr are all 0.
  - An in-flight bus transaction is abandoned; a busAck arriving after reset release is ignored.
- States: IDLE, BUSY, DONE.
- IDLE, arbitration:
  - If dReq and not (iReq and starveCnt==STARVE_LIMIT): grant D.
  - Else if iReq: grant I.
  - Else: stay in IDLE.
- On a grant:
  - On the next edge, load the bus registers from the winning port. For I, busWe=0000 and busWData=0.
  - Set busReq=1 and go to BUSY.
  - grantD is set to 1 for a D grant and 0 for an I grant.
- starveCnt update at each grant:
  - D grant with iReq high: starveCnt increments, saturating at STARVE_LIMIT.
  - I grant, or D grant with iReq low: starveCnt clears to 0.
- BUSY:
  - Bus outputs hold stable until busAck.
  - busAck is combinationally forwarded to the owner's ack output in the same cycle.
  - busRData is routed combinationally to iData or dRData.
  - On the busAck edge, busReq drops to 0 and the state goes to DONE.
- DONE:
  - A single bubble cycle, so the requester can drop its req; then go to IDLE.
  - Minimum transaction: grant edge, then at least 1 BUSY cycle, then DONE, so back-to-back issue is every ≥3 cycles.
- Outputs outside the transaction:
  - iData and dRData equal busRData at all times; they are meaningful only with the matching ack.
  - The non-owner port never sees an ack.
- Boundary cases:
  - busAck in IDLE or DONE is ignored.
  - A req deasserted while its port is waiting is legal and simply not granted.
  - A req deasserted after the grant is a protocol violation; the transaction still completes and the ack is still pulsed.
  - dWrite≠0 with dAddr unaligned is passed through unchanged; alignment checks belong to the requester.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit+ counter clears on entry to BUSY and increments each BUSY cycle without busAck.
  - When the count reaches TIMEOUT: pulse iErr or dErr for the owner, set busReq=0, and go to DONE.
  - busAck in the same cycle as the timeout wins: ack is pulsed, no err.
- Not defined:
  - No counter is built; iErr and dErr are tied to 0.
  - BUSY waits indefinitely.

Test Plan:
- Reset then D read: dReq=1, dAddr=0x100, dWrite=0; busAck 2 cycles after busReq with busRData=0xDEADBEEF.
  - busAddr=0x100, busWe=0; dAck pulses exactly once with dRData=0xDEADBEEF; iAck stays 0.
- Simultaneous iReq and dReq, STARVE_LIMIT=4, D re-requesting continuously.
  - Grant order is D,D,D,D,I, then D again; starveCnt returns to 0 after the I grant.
- D store: dWrite=0011, dWData=0x12345678, dAddr=0x2.
  - busWe=0011 and busWData=0x12345678 held stable until busAck; the next grant is no earlier than 2 cycles after the ack.
- Async reset mid-BUSY: drop rstn for half a cycle while busReq=1.
  - busReq drops to 0 immediately with no clock edge; a later stray busAck produces no iAck or dAck.
- MEM_ARB_TIMEOUT_EN defined with TIMEOUT=8, I fetch, busAck never sent.
  - iErr pulses on the 8th BUSY cycle and busReq drops; a following D request is granted normally.
- MEM_ARB_TIMEOUT_EN defined, busAck arriving on the exact timeout cycle.
  - Ack is pulsed and err is not.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//
// Bundles every handshake and bus signal of the memory port arbiter so that
// requesters, the arbiter and the memory model connect through one object.
//
// Signal groups:
//   I port   : iReq, iAddr (to arbiter); iAck, iData, iErr (from arbiter)
//   D port   : dReq, dAddr, dWrite, dWData (to arbiter); dAck, dRData, dErr
//   Bus side : busReq, busAddr, busWe, busWData (from arbiter);
//              busAck, busRData (to arbiter)
//
// Modports:
//   slave  : the arbiter's view (it serves the I/D requesters)
//   master : the environment's view (requesters plus the memory bus)
interface mem_port_arbiter_if;
    logic        iReq;
    logic [31:0] iAddr;
    logic        iAck;
    logic [31:0] iData;
    logic        iErr;

    logic        dReq;
    logic [31:0] dAddr;
    logic [3:0]  dWrite;
    logic [31:0] dWData;
    logic        dAck;
    logic [31:0] dRData;
    logic        dErr;

    logic        busReq;
    logic [31:0] busAddr;
    logic [3:0]  busWe;
    logic [31:0] busWData;
    logic        busAck;
    logic [31:0] busRData;

    modport slave (
        input  iReq, iAddr, dReq, dAddr, dWrite, dWData, busAck, busRData,
        output iAck, iData, iErr, dAck, dRData, dErr,
               busReq, busAddr, busWe, busWData
    );

    modport master (
        output iReq, iAddr, dReq, dAddr, dWrite, dWData, busAck, busRData,
        input  iAck, iData, iErr, dAck, dRData, dErr,
               busReq, busAddr, busWe, busWData
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-ported memory bus between the instruction-fetch port (I)
// and the EX-stage data port (D). D has fixed priority, but once D has won
// STARVE_LIMIT grants in a row while I was waiting, I is forced to win.
// Each transaction is grant edge -> BUSY (until busAck) -> one DONE bubble.
//
// Ports:
//   clk     : clock, rising edge
//   rstn    : asynchronous active-low reset
//   arb     : mem_port_arbiter_if.slave (I/D handshakes and memory bus)
//   grantD  : 1 while the current or last bus owner is D (debug)
//
// Parameters:
//   STARVE_LIMIT : consecutive D grants tolerated while I waits
//   TIMEOUT      : BUSY cycles before a transaction without busAck is aborted
//
// Build option:
//   MEM_ARB_TIMEOUT_EN : when defined, a watchdog aborts a transaction after
//   TIMEOUT BUSY cycles and pulses iErr/dErr; when undefined BUSY waits
//   forever and iErr/dErr are constant 0.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              rstn,
    mem_port_arbiter_if.slave arb,
    output logic              grantD
);
    localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state, state_n;
    logic                bus_req_q, bus_req_n;
    logic [31:0]         bus_addr_q, bus_addr_n;
    logic [3:0]          bus_we_q, bus_we_n;
    logic [31:0]         bus_wdata_q, bus_wdata_n;
    logic                grant_d_q, grant_d_n;
    logic [STARVE_W-1:0] starve_cnt, starve_n;
    logic                d_wins;
    logic                busy_ack;
    logic                timeout_hit;

    // Degenerate parameter values leave a marker block in the elaborated hierarchy.
    if (STARVE_LIMIT < 1 || TIMEOUT < 1) begin : g_bad_params
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] to_cnt, to_cnt_n;

    // The count is 0 in the first BUSY cycle, so it equals TIMEOUT-1 in the
    // TIMEOUT-th BUSY cycle; that cycle aborts unless busAck arrives with it.
    assign timeout_hit = (state == BUSY) && !arb.busAck && (to_cnt == TO_LAST);

    // Held at zero while idle so every BUSY entry starts a fresh count.
    always_comb begin
        to_cnt_n = to_cnt;
        if (state == IDLE) begin
            to_cnt_n = '0;
        end else if (state == BUSY && !arb.busAck) begin
            to_cnt_n = to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt_n;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // D wins unless I is waiting and has already been passed over too often.
    assign d_wins   = arb.dReq && !(arb.iReq && starve_cnt == STARVE_MAX);
    assign busy_ack = (state == BUSY) && arb.busAck;

    // Completion is forwarded combinationally to the owner only; grant_d_q
    // names the owner for the whole BUSY phase.
    assign arb.iAck   = busy_ack && !grant_d_q;
    assign arb.dAck   = busy_ack && grant_d_q;
    assign arb.iErr   = timeout_hit && !grant_d_q;
    assign arb.dErr   = timeout_hit && grant_d_q;
    assign arb.iData  = arb.busRData;
    assign arb.dRData = arb.busRData;

    assign arb.busReq   = bus_req_q;
    assign arb.busAddr  = bus_addr_q;
    assign arb.busWe    = bus_we_q;
    assign arb.busWData = bus_wdata_q;
    assign grantD       = grant_d_q;

    // Arbitration, bus register loading and the starvation counter.
    always_comb begin
        state_n     = state;
        bus_req_n   = bus_req_q;
        bus_addr_n  = bus_addr_q;
        bus_we_n    = bus_we_q;
        bus_wdata_n = bus_wdata_q;
        grant_d_n   = grant_d_q;
        starve_n    = starve_cnt;
        unique case (state)
            IDLE: begin
                if (d_wins) begin
                    state_n     = BUSY;
                    bus_req_n   = 1'b1;
                    bus_addr_n  = arb.dAddr;
                    bus_we_n    = arb.dWrite;
                    bus_wdata_n = arb.dWData;
                    grant_d_n   = 1'b1;
                    // Only grants that actually made I wait count towards starvation.
                    if (arb.iReq) begin
                        starve_n = (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1;
                    end else begin
                        starve_n = '0;
                    end
                end else if (arb.iReq) begin
                    state_n     = BUSY;
                    bus_req_n   = 1'b1;
                    bus_addr_n  = arb.iAddr;
                    bus_we_n    = 4'b0000;
                    bus_wdata_n = 32'h0;
                    grant_d_n   = 1'b0;
                    starve_n    = '0;
                end
            end
            BUSY: begin
                if (arb.busAck || timeout_hit) begin
                    state_n   = DONE;
                    bus_req_n = 1'b0;
                end
            end
            DONE: begin
                // Bubble cycle that lets the finished requester drop its req.
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            bus_req_q   <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_we_q    <= 4'b0000;
            bus_wdata_q <= 32'h0;
            grant_d_q   <= 1'b0;
            starve_cnt  <= '0;
        end else begin
            state       <= state_n;
            bus_req_q   <= bus_req_n;
            bus_addr_q  <= bus_addr_n;
            bus_we_q    <= bus_we_n;
            bus_wdata_q <= bus_wdata_n;
            grant_d_q   <= grant_d_n;
            starve_cnt  <= starve_n;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. A transaction-level model
// (current owner, pending bubble, D-win streak, captured bus request)
// predicts every output each cycle; directed phases pin that model with
// literal expectations, then a randomized phase exercises both requesters
// and a random-latency memory with stray acks.
//
// Ports of the DUT are reached through the mem_port_arbiter_if instance 'arb'.
// Timeout phases are compiled only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;
    localparam int TB_STARVE  = 4;
    localparam int TB_TIMEOUT = 8;

    logic clk;
    logic rstn;
    logic grantD;

    mem_port_arbiter_if arb();

    mem_port_arbiter #(
        .STARVE_LIMIT(TB_STARVE),
        .TIMEOUT     (TB_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .arb   (arb),
        .grantD(grantD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Model: owner -1 none, 0 I, 1 D
    int          m_owner  = -1;
    bit          m_bubble = 1'b0;
    int          m_streak = 0;
    bit          m_last_d = 1'b0;
    int          m_busy   = 0;
    logic [31:0] m_addr   = '0;
    logic [3:0]  m_we     = '0;
    logic [31:0] m_wdata  = '0;
    int          grant_log[$];
    int          d_ack_pulses = 0;
    bit          i_pend = 1'b0;
    bit          d_pend = 1'b0;

    task automatic compareWord(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareBit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic resetModel();
        m_owner  = -1;
        m_bubble = 1'b0;
        m_streak = 0;
        m_last_d = 1'b0;
        m_busy   = 0;
    endtask

    // Compare all outputs against the model, then advance the model across
    // the coming rising edge using the inputs currently driven.
    task automatic checkOutput();
        logic ack_now;
        logic hit;
        logic i_w;
        logic d_w;
        ack_now = arb.busAck;
        hit     = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        hit = (m_owner >= 0) && !ack_now && (m_busy == TB_TIMEOUT - 1);
`endif
        compareBit("busReq", arb.busReq, m_owner >= 0);
        if (m_owner >= 0) begin
            compareWord("busAddr", arb.busAddr, m_addr);
            compareWord("busWe", 32'(arb.busWe), 32'(m_we));
            compareWord("busWData", arb.busWData, m_wdata);
        end
        compareBit("grantD", grantD, m_last_d);
        compareBit("iAck", arb.iAck, (m_owner == 0) && ack_now);
        compareBit("dAck", arb.dAck, (m_owner == 1) && ack_now);
        compareBit("iErr", arb.iErr, (m_owner == 0) && hit);
        compareBit("dErr", arb.dErr, (m_owner == 1) && hit);
        if (ack_now) begin
            compareWord("iData", arb.iData, arb.busRData);
            compareWord("dRData", arb.dRData, arb.busRData);
        end
        if (arb.dAck === 1'b1) d_ack_pulses++;

        if (m_owner >= 0) begin
            if (ack_now || hit) begin
                if (m_owner == 0) i_pend = 1'b0;
                else              d_pend = 1'b0;
                m_owner  = -1;
                m_bubble = 1'b1;
            end else begin
                m_busy++;
            end
        end else if (m_bubble) begin
            m_bubble = 1'b0;
        end else begin
            i_w = arb.iReq;
            d_w = arb.dReq;
            m_busy = 0;
            if (d_w && !(i_w && m_streak >= TB_STARVE)) begin
                m_owner  = 1;
                m_addr   = arb.dAddr;
                m_we     = arb.dWrite;
                m_wdata  = arb.dWData;
                m_streak = i_w ? ((m_streak < TB_STARVE) ? m_streak + 1 : TB_STARVE) : 0;
                m_last_d = 1'b1;
                grant_log.push_back(1);
            end else if (i_w) begin
                m_owner  = 0;
                m_addr   = arb.iAddr;
                m_we     = 4'b0000;
                m_wdata  = 32'h0;
                m_streak = 0;
                m_last_d = 1'b0;
                grant_log.push_back(0);
            end
        end
    endtask

    task automatic tick();
        #1;
        checkOutput();
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    // Random requesters (hold req until done, occasional legal withdrawal
    // while still waiting) and a random-latency memory with stray acks.
    task automatic applyStimulus();
        if (!i_pend) begin
            if ($urandom_range(0, 3) == 0) begin
                i_pend    = 1'b1;
                arb.iAddr = $urandom();
            end
        end else if (m_owner != 0 && $urandom_range(0, 15) == 0) begin
            i_pend = 1'b0;
        end
        if (!d_pend) begin
            if ($urandom_range(0, 2) == 0) begin
                d_pend     = 1'b1;
                arb.dAddr  = $urandom();
                arb.dWrite = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
                arb.dWData = $urandom();
            end
        end else if (m_owner != 1 && $urandom_range(0, 15) == 0) begin
            d_pend = 1'b0;
        end
        arb.iReq     = i_pend;
        arb.dReq     = d_pend;
        arb.busAck   = (m_owner >= 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
        arb.busRData = $urandom();
    endtask

    // Let any in-flight transaction finish with requests low.
    task automatic drain();
        arb.iReq = 1'b0;
        arb.dReq = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (m_owner < 0 && !m_bubble) break;
            arb.busAck = (m_owner >= 0);
            tick();
            nextCycle();
        end
        arb.busAck = 1'b0;
        compareBit("drain_idle", (m_owner < 0) && !m_bubble, 1'b1);
    endtask

    initial begin
        #2_000_000;
        n_miss++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        int exp_order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        rstn         = 1'b0;
        arb.iReq     = 1'b0;
        arb.iAddr    = '0;
        arb.dReq     = 1'b0;
        arb.dAddr    = '0;
        arb.dWrite   = '0;
        arb.dWData   = '0;
        arb.busAck   = 1'b1;
        arb.busRData = '0;
        resetModel();

        // Reset values, with a stray busAck driven during reset
        nextCycle();
        nextCycle();
        #1;
        compareBit("rst_busReq", arb.busReq, 1'b0);
        compareWord("rst_busAddr", arb.busAddr, 32'h0);
        compareWord("rst_busWe", 32'(arb.busWe), 32'h0);
        compareWord("rst_busWData", arb.busWData, 32'h0);
        compareBit("rst_grantD", grantD, 1'b0);
        compareBit("rst_iAck", arb.iAck, 1'b0);
        compareBit("rst_dAck", arb.dAck, 1'b0);
        compareBit("rst_iErr", arb.iErr, 1'b0);
        compareBit("rst_dErr", arb.dErr, 1'b0);
        rstn       = 1'b1;
        arb.busAck = 1'b0;
        nextCycle();

        $display("[TB] D read");
        d_ack_pulses = 0;
        arb.dReq   = 1'b1;
        arb.dAddr  = 32'h100;
        arb.dWrite = 4'b0000;
        tick();
        nextCycle();
        tick();
        compareBit("dread_busReq", arb.busReq, 1'b1);
        compareWord("dread_busAddr", arb.busAddr, 32'h100);
        compareWord("dread_busWe", 32'(arb.busWe), 32'h0);
        nextCycle();
        tick();
        nextCycle();
        arb.busAck   = 1'b1;
        arb.busRData = 32'hDEADBEEF;
        tick();
        compareBit("dread_dAck", arb.dAck, 1'b1);
        compareWord("dread_dRData", arb.dRData, 32'hDEADBEEF);
        compareBit("dread_iAck", arb.iAck, 1'b0);
        nextCycle();
        arb.busAck = 1'b0;
        arb.dReq   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            nextCycle();
        end
        compareWord("dread_pulses", 32'(d_ack_pulses), 32'd1);

        $display("[TB] starvation");
        grant_log.delete();
        arb.iReq   = 1'b1;
        arb.iAddr  = 32'h4000;
        arb.dReq   = 1'b1;
        arb.dAddr  = 32'h200;
        arb.dWrite = 4'b0000;
        for (int k = 0; k < 200; k++) begin
            if (grant_log.size() >= 10) break;
            arb.busAck = (m_owner >= 0);
            tick();
            nextCycle();
        end
        if (grant_log.size() < 10) begin
            compareWord("starve_grant_count", 32'(grant_log.size()), 32'd10);
        end else begin
            for (int k = 0; k < 10; k++) begin
                compareWord("starve_order", 32'(grant_log[k]), 32'(exp_order[k]));
            end
        end
        drain();

        $display("[TB] D store");
        arb.dReq   = 1'b1;
        arb.dAddr  = 32'h2;
        arb.dWrite = 4'b0011;
        arb.dWData = 32'h12345678;
        tick();
        nextCycle();
        for (int k = 0; k < 3; k++) begin
            tick();
            compareWord("store_busWe", 32'(arb.busWe), 32'h3);
            compareWord("store_busWData", arb.busWData, 32'h12345678);
            compareWord("store_busAddr", arb.busAddr, 32'h2);
            nextCycle();
        end
        arb.busAck = 1'b1;
        tick();
        compareBit("store_dAck", arb.dAck, 1'b1);
        nextCycle();
        arb.busAck = 1'b0;
        arb.dReq   = 1'b0;
        arb.iReq   = 1'b1;
        arb.iAddr  = 32'h80;
        tick();
        compareBit("store_gap1", arb.busReq, 1'b0);
        nextCycle();
        tick();
        compareBit("store_gap2", arb.busReq, 1'b0);
        nextCycle();
        tick();
        compareBit("store_next_grant", arb.busReq, 1'b1);
        compareBit("store_next_owner", grantD, 1'b0);
        nextCycle();
        drain();

        $display("[TB] async reset in BUSY");
        arb.iReq  = 1'b1;
        arb.iAddr = 32'h300;
        tick();
        nextCycle();
        tick();
        rstn = 1'b0;
        #1;
        compareBit("arst_busReq", arb.busReq, 1'b0);
        compareWord("arst_busAddr", arb.busAddr, 32'h0);
        @(posedge clk);
        #2;
        rstn     = 1'b1;
        arb.iReq = 1'b0;
        resetModel();
        nextCycle();
        for (int k = 0; k < 2; k++) begin
            arb.busAck   = 1'b1;
            arb.busRData = 32'hBAD0BAD0;
            tick();
            compareBit("arst_stray_iAck", arb.iAck, 1'b0);
            compareBit("arst_stray_dAck", arb.dAck, 1'b0);
            nextCycle();
        end
        arb.busAck = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
        $display("[TB] timeout");
        arb.iReq  = 1'b1;
        arb.iAddr = 32'h500;
        tick();
        nextCycle();
        for (int k = 1; k <= 8; k++) begin
            tick();
            compareBit("to_busReq", arb.busReq, 1'b1);
            compareBit("to_iErr", arb.iErr, k == 8);
            nextCycle();
        end
        arb.iReq   = 1'b0;
        arb.dReq   = 1'b1;
        arb.dAddr  = 32'h600;
        arb.dWrite = 4'b0000;
        tick();
        compareBit("to_after_busReq", arb.busReq, 1'b0);
        nextCycle();
        tick();
        nextCycle();
        arb.busAck = 1'b1;
        tick();
        compareBit("to_d_busReq", arb.busReq, 1'b1);
        compareBit("to_d_grantD", grantD, 1'b1);
        compareBit("to_d_dAck", arb.dAck, 1'b1);
        nextCycle();
        arb.busAck = 1'b0;
        drain();

        $display("[TB] ack on timeout cycle");
        arb.iReq  = 1'b1;
        arb.iAddr = 32'h700;
        tick();
        nextCycle();
        for (int k = 1; k <= 8; k++) begin
            arb.busAck = (k == 8);
            tick();
            if (k == 8) begin
                compareBit("to_race_iAck", arb.iAck, 1'b1);
                compareBit("to_race_iErr", arb.iErr, 1'b0);
            end
            nextCycle();
        end
        arb.busAck = 1'b0;
        drain();
`endif

        $display("[TB] random traffic");
        i_pend = 1'b0;
        d_pend = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            applyStimulus();
            tick();
            nextCycle();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
